spi_boot_loader: RTL and testbench
==================================

SPI_BOOT_LOADER -- requirements
Module: spi_boot_loader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4; SCK half-period in clk cycles, legal range 1..255.
REQ-002 SHALL have parameter FLASH_BASE, default 24'h300000; flash byte address of the program image.
REQ-003 SHALL have parameter MAX_WORDS, default 4096; maximum 32-bit words copied, legal range 0..65535.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports:
- clk  in  1  system clock (clk_50M domain)
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a load
- spi_miso  in  1  flash serial data out
- spi_sck  out  1  SPI clock, mode 0, routed to STARTUPE2 USRCCLKO
- spi_cs  out  1  flash chip select, active low
- spi_mosi  out  1  flash serial data in
- imem_prog_ena  out  1  instruction-memory write strobe
- imem_en  out  1  instruction-memory enable
- imem_addr  out  32  instruction-memory byte address
- imem_din  out  32  instruction word
- core_hold  out  1  holds the core in reset while high
- busy  out  1  load in progress
- done  out  1  sticky; set when a load completes
- word_cnt  out  16  number of words written in the current or last load

Function
REQ-005 SHALL implement FSM states IDLE, CMD, DATA, WRITE, DONE.
REQ-006 SHALL move IDLE->CMD on start; when MAX_WORDS=0 it SHALL instead move IDLE->DONE in one cycle and never assert spi_cs.
REQ-007 In CMD, SHALL drive spi_cs=0 and shift out MSB-first the 32 bits {8'h03, FLASH_BASE}, then go to DATA.
REQ-008 SCK SHALL idle low and toggle every CLK_DIV clk cycles; MOSI SHALL change only on SCK falling edges (or on cs assertion for bit 0); MISO SHALL be sampled on the clk cycle in which SCK rises.
REQ-009 In DATA, SHALL shift in 32 bits; flash bytes b0,b1,b2,b3, in arrival order and MSB-first within each byte, SHALL form imem_din = {b3,b2,b1,b0} (little-endian).
REQ-010 DATA->WRITE SHALL occur on the clk cycle after the 32nd rising-edge sample; SCK SHALL stay low and spi_cs low (continuous read) while in WRITE.
REQ-011 In WRITE, imem_prog_ena and imem_en SHALL be high for exactly one cycle, with imem_addr = word_cnt*4, then word_cnt SHALL increment.
REQ-012 WRITE->DATA SHALL occur if the new word_cnt < MAX_WORDS and the word written != 32'hFFFFFFFF; otherwise WRITE->DONE.
REQ-013 An erased word (32'hFFFFFFFF) SHALL still be written before termination (acts as a terminator).
REQ-014 On entry to DONE, SHALL drive spi_cs=1, spi_sck=0, busy=0, done=1, core_hold=0; DONE->CMD SHALL occur on a new start, clearing done and word_cnt.
REQ-015 start SHALL be ignored while busy=1.
REQ-016 busy SHALL be 1 in CMD, DATA and WRITE; core_hold SHALL be 1 from reset until the first entry to DONE, and again during any reload.
REQ-017 word_cnt SHALL be 16 bits wide; the MAX_WORDS bound guarantees it never wraps.

Reset
REQ-018 On rst_n=0 (asynchronous, in any state, including mid-transfer), SHALL set: state IDLE, spi_cs=1, spi_sck=0, spi_mosi=0, imem_prog_ena=0, imem_en=0, imem_addr=0, imem_din=0, busy=0, done=0, word_cnt=0, core_hold=1.
REQ-019 Reset deassertion SHALL NOT itself start a load; a start pulse is required.

Structure
REQ-020 Package rv_boot_pkg SHALL hold the state enum boot_state_t, FLASH_READ_CMD=8'h03 and ERASED_WORD=32'hFFFFFFFF.
REQ-021 A sub-module spi_shift_engine (SCK divider plus a 32-bit bidirectional shift register with a bit counter and a done pulse) SHALL be instantiated once; the FSM stays in spi_boot_loader.

Verification
REQ-022 Run with CLK_DIV=2, MAX_WORDS=4 against a flash model containing bytes 13 00 00 00 93 00 10 00 ... -> writes 0x00000013 @0 and 0x00100093 @4, through @12; done=1; word_cnt=4.
REQ-023 Check the command phase: MOSI bits sampled on SCK rising edges equal 0x03300000; spi_cs is low before the first SCK rise; SCK high/low each last 2 clk cycles.
REQ-024 Make word 2 = FF FF FF FF with MAX_WORDS=8 -> exactly 3 writes (the last is 0xFFFFFFFF @8), then DONE with word_cnt=3.
REQ-025 Assert rst_n low during the DATA phase of word 1 -> all outputs match REQ-018 immediately with no further imem_prog_ena; a later start performs a full reload from address 0.
REQ-026 With MAX_WORDS=0, pulse start -> done=1 on the next cycle, spi_cs never low, no writes.
REQ-027 Pulse start again while busy=1 -> ignored: the write sequence and word_cnt are unchanged versus the reference run.

Source files
------------

// File: rtl/spi_boot_loader_pkg.sv
// ============================================================================
//  Package     : rv_boot_pkg
//  Description : Shared types and constants for the SPI flash boot loader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_boot_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } boot_state_t;

    localparam logic [7:0]  FLASH_READ_CMD = 8'h03;
    localparam logic [31:0] ERASED_WORD    = 32'hFFFF_FFFF;

    // Flash bytes arrive b0 first; the instruction word is little-endian.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_boot_loader_if.sv
// ============================================================================
//  Interface   : spi_boot_loader_if
//  Description : SPI flash pins and instruction-memory write port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_boot_loader_if;

    logic        spi_sck;
    logic        spi_cs;
    logic        spi_mosi;
    logic        spi_miso;
    logic        imem_prog_ena;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_din;

    modport master (
        output spi_sck, spi_cs, spi_mosi,
        output imem_prog_ena, imem_en, imem_addr, imem_din,
        input  spi_miso
    );

    modport slave (
        input  spi_sck, spi_cs, spi_mosi,
        input  imem_prog_ena, imem_en, imem_addr, imem_din,
        output spi_miso
    );

endinterface

`default_nettype wire

// File: rtl/spi_boot_loader_shift_engine.sv
// ============================================================================
//  Module      : spi_shift_engine
//  Description : Mode-0 SCK divider with a shared 32-bit TX/RX shift register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_shift_engine #(
    parameter int CLK_DIV = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        start,
    input  wire logic [31:0] tx_word,
    input  wire logic        miso,
    output logic             sck,
    output logic             mosi,
    output logic [31:0]      rx_word,
    output logic             done
);

    localparam logic [7:0] c_div_last = 8'(CLK_DIV - 1);

    logic        r_active;
    logic        r_sck;
    logic        r_mosi;
    logic        r_done;
    logic [7:0]  r_div;
    logic [5:0]  r_cnt;
    logic [31:0] r_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_sck    <= 1'b0;
            r_mosi   <= 1'b0;
            r_done   <= 1'b0;
            r_div    <= 8'd0;
            r_cnt    <= 6'd0;
            r_sr     <= 32'd0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                // MSB goes out together with the load so it is valid before the first rise.
                r_active <= 1'b1;
                r_sck    <= 1'b0;
                r_div    <= 8'd0;
                r_cnt    <= 6'd0;
                r_sr     <= tx_word;
                r_mosi   <= tx_word[31];
            end else if (r_active) begin
                if (r_cnt == 6'd32) begin
                    r_active <= 1'b0;
                    r_sck    <= 1'b0;
                end else if (r_div == c_div_last) begin
                    r_div <= 8'd0;
                    r_sck <= ~r_sck;
                    if (!r_sck) begin
                        r_sr  <= {r_sr[30:0], miso};
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == 6'd31) begin
                            r_done <= 1'b1;
                        end
                    end else begin
                        r_mosi <= r_sr[31];
                    end
                end else begin
                    r_div <= r_div + 8'd1;
                end
            end
        end
    end

    assign sck     = r_sck;
    assign mosi    = r_mosi;
    assign rx_word = r_sr;
    assign done    = r_done;

endmodule

`default_nettype wire

// File: rtl/spi_boot_loader.sv
// ============================================================================
//  Module      : spi_boot_loader
//  Description : Copies a program image from SPI flash into instruction memory.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_boot_loader
    import rv_boot_pkg::*;
#(
    parameter int          CLK_DIV    = 4,
    parameter logic [23:0] FLASH_BASE = 24'h300000,
    parameter int          MAX_WORDS  = 4096
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               start,
    spi_boot_loader_if.master       bus,
    output logic                    core_hold,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             word_cnt
);

    localparam logic [16:0] c_max_words = 17'(MAX_WORDS);
    localparam logic [31:0] c_read_cmd  = {FLASH_READ_CMD, FLASH_BASE};

    boot_state_t r_state;
    boot_state_t w_state_next;

    logic        w_eng_start;
    logic [31:0] w_eng_tx;
    logic        w_eng_done;
    logic [31:0] w_eng_rx;
    logic        w_eng_sck;
    logic        w_eng_mosi;

    logic [15:0] r_word_cnt;
    logic [31:0] r_din;
    logic        r_done;
    logic        r_core_hold;

    logic [16:0] w_cnt_inc;
    logic        w_start_ok;
    logic        w_enter_done;
    logic        w_busy;

    assign w_cnt_inc  = {1'b0, r_word_cnt} + 17'd1;
    assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));

    spi_shift_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_eng_start),
        .tx_word (w_eng_tx),
        .miso    (bus.spi_miso),
        .sck     (w_eng_sck),
        .mosi    (w_eng_mosi),
        .rx_word (w_eng_rx),
        .done    (w_eng_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_eng_start  = 1'b0;
        w_eng_tx     = 32'd0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    if (c_max_words == 17'd0) begin
                        w_state_next = DONE;
                    end else begin
                        w_state_next = CMD;
                        w_eng_start  = 1'b1;
                        w_eng_tx     = c_read_cmd;
                    end
                end
            end
            CMD: begin
                if (w_eng_done) begin
                    w_state_next = DATA;
                    w_eng_start  = 1'b1;
                end
            end
            DATA: begin
                if (w_eng_done) begin
                    w_state_next = WRITE;
                end
            end
            WRITE: begin
                // CS stays low between words: the flash keeps streaming (continuous read).
                if ((w_cnt_inc < c_max_words) && (r_din != ERASED_WORD)) begin
                    w_state_next = DATA;
                    w_eng_start  = 1'b1;
                end else begin
                    w_state_next = DONE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // A restart from DONE that goes straight back to DONE must still re-set done.
    assign w_enter_done = (w_state_next == DONE) && ((r_state != DONE) || start);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_cnt  <= 16'd0;
            r_din       <= 32'd0;
            r_done      <= 1'b0;
            r_core_hold <= 1'b1;
        end else begin
            if (w_start_ok) begin
                r_word_cnt  <= 16'd0;
                r_done      <= 1'b0;
                r_core_hold <= 1'b1;
            end
            if ((r_state == DATA) && w_eng_done) begin
                r_din <= bswap32(w_eng_rx);
            end
            if (r_state == WRITE) begin
                r_word_cnt <= w_cnt_inc[15:0];
            end
            if (w_enter_done) begin
                r_done      <= 1'b1;
                r_core_hold <= 1'b0;
            end
        end
    end

    assign w_busy = (r_state == CMD) || (r_state == DATA) || (r_state == WRITE);

    assign bus.spi_cs        = ~w_busy;
    assign bus.spi_sck       = w_eng_sck & w_busy;
    assign bus.spi_mosi      = w_eng_mosi & w_busy;
    assign bus.imem_prog_ena = (r_state == WRITE);
    assign bus.imem_en       = (r_state == WRITE);
    assign bus.imem_addr     = {14'd0, r_word_cnt, 2'b00};
    assign bus.imem_din      = r_din;

    assign core_hold = r_core_hold;
    assign busy      = w_busy;
    assign done      = r_done;
    assign word_cnt  = r_word_cnt;

endmodule

`default_nettype wire

// File: tb/tb_spi_boot_loader.sv
// ============================================================================
//  Module      : tb_spi_boot_loader
//  Description : Self-checking bench: flash models plus an image-level write model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_boot_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic hold_a, busy_a, done_a, hold_b, busy_b, done_b, hold_c, busy_c, done_c;
    logic [15:0] cnt_a, cnt_b, cnt_c;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  img_a [0:31];
    logic [7:0]  img_b [0:31];
    logic [63:0] exp_a [$];
    logic [63:0] exp_b [$];
    logic [63:0] got_a [$];
    logic [63:0] got_b [$];

    always #5 clk = ~clk;

    spi_boot_loader_if ifa ();
    spi_boot_loader_if ifb ();
    spi_boot_loader_if ifc ();

    spi_boot_loader #(.CLK_DIV(2), .FLASH_BASE(24'h300000), .MAX_WORDS(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .bus(ifa),
        .core_hold(hold_a), .busy(busy_a), .done(done_a), .word_cnt(cnt_a));

    spi_boot_loader #(.CLK_DIV(2), .FLASH_BASE(24'h300000), .MAX_WORDS(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .bus(ifb),
        .core_hold(hold_b), .busy(busy_b), .done(done_b), .word_cnt(cnt_b));

    spi_boot_loader #(.CLK_DIV(2), .FLASH_BASE(24'h300000), .MAX_WORDS(0)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .bus(ifc),
        .core_hold(hold_c), .busy(busy_c), .done(done_c), .word_cnt(cnt_c));

    // Flash model: after 32 command bits, each SCK fall presents the next image bit.
    int fa = 0;
    int fb = 0;
    always @(negedge ifa.spi_sck or posedge ifa.spi_cs) begin
        if (ifa.spi_cs) fa = 0;
        else            fa = fa + 1;
    end
    always @(negedge ifb.spi_sck or posedge ifb.spi_cs) begin
        if (ifb.spi_cs) fb = 0;
        else            fb = fb + 1;
    end
    always_comb begin
        int k;
        k = fa - 32;
        ifa.spi_miso = 1'b0;
        if (fa >= 32 && k < 256) ifa.spi_miso = img_a[k / 8][7 - (k % 8)];
    end
    always_comb begin
        int k;
        k = fb - 32;
        ifb.spi_miso = 1'b0;
        if (fb >= 32 && k < 256) ifb.spi_miso = img_b[k / 8][7 - (k % 8)];
    end
    assign ifc.spi_miso = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Expected writes: little-endian words from the image, stop after MAX or after an erased word.
    task automatic model_load(input int sel, input int max_words);
        logic [31:0] w;
        for (int i = 0; i < max_words && i < 8; i++) begin
            if (sel == 0) w = {img_a[4*i+3], img_a[4*i+2], img_a[4*i+1], img_a[4*i]};
            else          w = {img_b[4*i+3], img_b[4*i+2], img_b[4*i+1], img_b[4*i]};
            if (sel == 0) exp_a.push_back({32'(4*i), w});
            else          exp_b.push_back({32'(4*i), w});
            if (w == 32'hFFFF_FFFF) break;
        end
    endtask

    task automatic check_write(input int sel, input logic [31:0] addr, input logic [31:0] data);
        logic [63:0] e;
        int have;
        have = (sel == 0) ? exp_a.size() : exp_b.size();
        chk((sel == 0) ? "a_write_expected" : "b_write_expected", 64'(have > 0), 64'd1);
        if (have > 0) begin
            e = (sel == 0) ? exp_a.pop_front() : exp_b.pop_front();
            chk((sel == 0) ? "a_write_addr" : "b_write_addr", 64'(addr), 64'(e[63:32]));
            chk((sel == 0) ? "a_write_data" : "b_write_data", 64'(data), 64'(e[31:0]));
        end
        if (sel == 0) got_a.push_back({addr, data});
        else          got_b.push_back({addr, data});
    endtask

    task automatic pulse(input logic a, input logic b, input logic c);
        @(negedge clk);
        start_a = a; start_b = b; start_c = c;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    endtask

    // Per-cycle compare process, including SCK timing and command capture on DUT A.
    logic        a_sck_q = 1'b0;
    logic        a_cs_q  = 1'b1;
    int          a_run   = 0;
    int          a_rises = 0;
    logic [31:0] a_cmd   = 32'd0;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("a_en_vs_prog", ifa.imem_en, ifa.imem_prog_ena);
            chk("b_en_vs_prog", ifb.imem_en, ifb.imem_prog_ena);
            chk("a_cs_vs_busy", ifa.spi_cs, !busy_a);
            chk("b_cs_vs_busy", ifb.spi_cs, !busy_b);
            chk("c_cs_high", ifc.spi_cs, 1'b1);
            chk("c_no_write", ifc.imem_prog_ena, 1'b0);
        end
        if (ifa.imem_prog_ena) check_write(0, ifa.imem_addr, ifa.imem_din);
        if (ifb.imem_prog_ena) check_write(1, ifb.imem_addr, ifb.imem_din);

        if (ifa.spi_sck && !a_sck_q) chk("a_cs_low_at_rise", ifa.spi_cs, 1'b0);
        if (ifa.spi_cs) begin
            a_run = 0;
            a_rises = 0;
        end else if (a_cs_q) begin
            a_run = 1;
            a_rises = 0;
        end else if (ifa.spi_sck != a_sck_q) begin
            if (ifa.spi_sck) begin
                if (a_rises < 32) begin
                    chk("a_sck_low_len", 64'(a_run), 64'd2);
                    a_cmd = {a_cmd[30:0], ifa.spi_mosi};
                end
                a_rises++;
                if (a_rises == 32) chk("a_cmd_word", a_cmd, 32'h0330_0000);
            end else if (a_rises < 32) begin
                chk("a_sck_high_len", 64'(a_run), 64'd2);
            end
            a_run = 1;
        end else begin
            a_run++;
        end
        a_sck_q = ifa.spi_sck;
        a_cs_q  = ifa.spi_cs;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int t;
        for (int i = 0; i < 32; i++) begin
            img_a[i] = 8'hFF;
            img_b[i] = 8'(i);
        end
        {img_a[0], img_a[1], img_a[2], img_a[3]}     = 32'h1300_0000;
        {img_a[4], img_a[5], img_a[6], img_a[7]}     = 32'h9300_1000;
        {img_a[8], img_a[9], img_a[10], img_a[11]}   = 32'hB712_3412;
        {img_a[12], img_a[13], img_a[14], img_a[15]} = 32'h6F00_0000;
        {img_a[16], img_a[17], img_a[18], img_a[19]} = 32'hDDCC_BBAA;
        {img_b[0], img_b[1], img_b[2], img_b[3]}     = 32'h1300_0000;
        {img_b[4], img_b[5], img_b[6], img_b[7]}     = 32'h9300_1000;
        {img_b[8], img_b[9], img_b[10], img_b[11]}   = 32'hFFFF_FFFF;
        {img_b[12], img_b[13], img_b[14], img_b[15]} = 32'h1122_3344;

        repeat (3) @(negedge clk);
        chk("rst_cs", ifa.spi_cs, 1'b1);
        chk("rst_sck", ifa.spi_sck, 1'b0);
        chk("rst_mosi", ifa.spi_mosi, 1'b0);
        chk("rst_prog", ifa.imem_prog_ena, 1'b0);
        chk("rst_en", ifa.imem_en, 1'b0);
        chk("rst_addr", ifa.imem_addr, 32'd0);
        chk("rst_din", ifa.imem_din, 32'd0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_cnt", cnt_a, 16'd0);
        chk("rst_hold", hold_a, 1'b1);

        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_autostart_busy", busy_a, 1'b0);
        chk("no_autostart_cs", ifa.spi_cs, 1'b1);
        chk("no_autostart_hold", hold_a, 1'b1);

        // Reference run on A, erased-word termination on B.
        model_load(0, 4);
        model_load(1, 8);
        pulse(1'b1, 1'b1, 1'b0);
        repeat (200) @(negedge clk);
        chk("a_busy_at_extra_start", busy_a, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        t = 0;
        while (!(done_a && done_b) && t < 6000) begin @(negedge clk); t++; end
        chk("ab_finish_in_time", 64'(done_a && done_b), 64'd1);
        chk("a_cnt", cnt_a, 16'd4);
        chk("a_hold", hold_a, 1'b0);
        chk("a_busy", busy_a, 1'b0);
        chk("a_cs", ifa.spi_cs, 1'b1);
        chk("a_sck", ifa.spi_sck, 1'b0);
        chk("a_pending", 64'(exp_a.size()), 64'd0);
        chk("a_nwrites", 64'(got_a.size()), 64'd4);
        if (got_a.size() == 4) begin
            chk("a_w0", got_a[0], {32'd0, 32'h0000_0013});
            chk("a_w1", got_a[1], {32'd4, 32'h0010_0093});
            chk("a_w2", got_a[2], {32'd8, 32'h1234_12B7});
            chk("a_w3", got_a[3], {32'd12, 32'h0000_006F});
        end
        chk("b_cnt", cnt_b, 16'd3);
        chk("b_done", done_b, 1'b1);
        chk("b_nwrites", 64'(got_b.size()), 64'd3);
        if (got_b.size() == 3) chk("b_w2", got_b[2], {32'd8, 32'hFFFF_FFFF});

        // MAX_WORDS = 0: immediate completion.
        chk("c_done_before", done_c, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        chk("c_done_next", done_c, 1'b1);
        chk("c_busy", busy_c, 1'b0);
        chk("c_cnt", cnt_c, 16'd0);
        chk("c_hold", hold_c, 1'b0);

        // Reload on A, then reset during word 1.
        got_a.delete();
        model_load(0, 4);
        pulse(1'b1, 1'b0, 1'b0);
        chk("reload_done_clr", done_a, 1'b0);
        chk("reload_hold", hold_a, 1'b1);
        chk("reload_cnt", cnt_a, 16'd0);
        chk("reload_busy", busy_a, 1'b1);
        t = 0;
        while (got_a.size() < 1 && t < 3000) begin @(negedge clk); t++; end
        chk("a_first_write_in_time", 64'(got_a.size()), 64'd1);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        exp_a.delete();
        exp_b.delete();
        #1;
        chk("mid_rst_cs", ifa.spi_cs, 1'b1);
        chk("mid_rst_sck", ifa.spi_sck, 1'b0);
        chk("mid_rst_mosi", ifa.spi_mosi, 1'b0);
        chk("mid_rst_prog", ifa.imem_prog_ena, 1'b0);
        chk("mid_rst_addr", ifa.imem_addr, 32'd0);
        chk("mid_rst_din", ifa.imem_din, 32'd0);
        chk("mid_rst_busy", busy_a, 1'b0);
        chk("mid_rst_cnt", cnt_a, 16'd0);
        chk("mid_rst_hold", hold_a, 1'b1);
        repeat (3) @(negedge clk);
        chk("mid_rst_no_more_writes", 64'(got_a.size()), 64'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        got_a.delete();
        model_load(0, 4);
        pulse(1'b1, 1'b0, 1'b0);
        t = 0;
        while (!done_a && t < 6000) begin @(negedge clk); t++; end
        chk("reload_finish_in_time", done_a, 1'b1);
        chk("reload_final_cnt", cnt_a, 16'd4);
        chk("reload_nwrites", 64'(got_a.size()), 64'd4);
        if (got_a.size() > 0) chk("reload_w0", got_a[0], {32'd0, 32'h0000_0013});
        chk("reload_pending", 64'(exp_a.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
